// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt collector: FSM state encoding and default sizing.
package irq_pkg;

  localparam int DEF_N_SRC   = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_HOLDOFF = 2;

  localparam logic [1:0] ENC_IDLE    = 2'd0;
  localparam logic [1:0] ENC_ACTIVE  = 2'd1;
  localparam logic [1:0] ENC_HOLDOFF = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ENC_IDLE,
    S_ACTIVE  = ENC_ACTIVE,
    S_HOLDOFF = ENC_HOLDOFF
  } irq_state_t;

  // Counter width able to hold HOLDOFF-1; never narrower than one bit.
  function automatic int hcnt_width(input int holdoff);
    return (holdoff > 1) ? $clog2(holdoff) : 1;
  endfunction

endpackage

// File: rtl/lsb_pri_enc.sv
// Combinational lowest-set-bit priority encoder: index of the lowest request plus an any flag.
module lsb_pri_enc #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set bit is the last assignment and wins.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/irq_or_collector.sv
// Collects level event lines into one registered interrupt with sticky pending bits,
// clear handshake, lowest-index id, post-clear hold-off and a saturating event counter.
module irq_or_collector
  import irq_pkg::*;
#(
  parameter int N_SRC   = DEF_N_SRC,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src,
  input  logic [N_SRC-1:0]         mask_en,
  input  logic                     clr_valid,
  input  logic [N_SRC-1:0]         clr_mask,
  output logic                     clr_ready,
  output logic                     irq,
  output logic [$clog2(N_SRC)-1:0] irq_id,
  output logic [N_SRC-1:0]         pend,
  output logic [CNT_W-1:0]         evt_cnt
);

  localparam int ID_W   = $clog2(N_SRC);
  localparam int HCNT_W = hcnt_width(HOLDOFF);

  logic [N_SRC-1:0]  src_q;
  logic [N_SRC-1:0]  mask_q;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  act;
  logic              accept;
  logic [ID_W-1:0]   enc_idx;
  logic              enc_any;
  irq_state_t        state;
  irq_state_t        state_nxt;
  logic [ID_W-1:0]   id_nxt;
  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] hcnt_nxt;
  logic              irq_nxt;

  assign rise   = src & ~src_q;
  assign act    = pend & mask_q;
  assign accept = clr_valid & clr_ready;

  lsb_pri_enc #(.N(N_SRC), .IW(ID_W)) u_enc (
    .req (act),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Edge history and mask snapshot track their inputs through reset so held levels never count as edges.
  always_ff @(posedge clk) begin
    src_q  <= src;
    mask_q <= mask_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      irq       <= 1'b0;
      irq_id    <= '0;
      hcnt      <= '0;
      clr_ready <= 1'b0;
      pend      <= '0;
      evt_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      irq       <= irq_nxt;
      irq_id    <= id_nxt;
      hcnt      <= hcnt_nxt;
      clr_ready <= 1'b1;
      // A rise on a bit being cleared keeps it set.
      pend      <= rise | (pend & ~(clr_mask & {N_SRC{accept}}));
      if ((|rise) && (evt_cnt != {CNT_W{1'b1}})) evt_cnt <= evt_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enc_any) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (accept && clr_mask[irq_id]) state_nxt = (HOLDOFF > 0) ? S_HOLDOFF : S_IDLE;
        else if (!act[irq_id])          state_nxt = S_IDLE;
      end
      S_HOLDOFF: begin
        if (hcnt == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    id_nxt   = irq_id;
    hcnt_nxt = hcnt;
    irq_nxt  = (state_nxt == S_ACTIVE);
    if (state == S_IDLE && enc_any) id_nxt = enc_idx;
    if (state == S_ACTIVE && state_nxt == S_HOLDOFF) hcnt_nxt = HCNT_W'(HOLDOFF - 1);
    else if (state == S_HOLDOFF && hcnt != '0)       hcnt_nxt = hcnt - 1'b1;
  end

endmodule

// File: tb/tb_irq_or_collector.sv
// Scoreboard bench for irq_or_collector (N_SRC=4, CNT_W=4, HOLDOFF=2) using directed vectors.
module tb_irq_or_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src;
  logic [3:0] mask_en;
  logic       clr_valid;
  logic [3:0] clr_mask;
  logic       clr_ready;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pend;
  logic [3:0] evt_cnt;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [4:0] C_IRQ = 5'b00001;
  localparam logic [4:0] C_ID  = 5'b00010;
  localparam logic [4:0] C_PND = 5'b00100;
  localparam logic [4:0] C_CNT = 5'b01000;
  localparam logic [4:0] C_RDY = 5'b10000;
  localparam logic [4:0] C_ALL = 5'b11111;

  typedef struct {
    string      name;
    logic [4:0] sel;
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] cnt;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  irq_or_collector #(.N_SRC(4), .CNT_W(4), .HOLDOFF(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .mask_en   (mask_en),
    .clr_valid (clr_valid),
    .clr_mask  (clr_mask),
    .clr_ready (clr_ready),
    .irq       (irq),
    .irq_id    (irq_id),
    .pend      (pend),
    .evt_cnt   (evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic [3:0] s, input logic [3:0] m,
                     input logic cv, input logic [3:0] cm);
    rst = r; src = s; mask_en = m; clr_valid = cv; clr_mask = cm;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] sel, input logic i,
                            input logic [1:0] id, input logic [3:0] p,
                            input logic [3:0] c, input logic rd);
    exp_t e;
    e.name = nm; e.sel = sel; e.irq = i; e.id = id; e.pend = p; e.cnt = c; e.rdy = rd;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input string fld, input logic [3:0] a, input logic [3:0] x);
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, fld, a, x, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel[0]) chk(e.name, "irq",       {3'b0, irq},       {3'b0, e.irq});
        if (e.sel[1]) chk(e.name, "irq_id",    {2'b0, irq_id},    {2'b0, e.id});
        if (e.sel[2]) chk(e.name, "pend",      pend,              e.pend);
        if (e.sel[3]) chk(e.name, "evt_cnt",   evt_cnt,           e.cnt);
        if (e.sel[4]) chk(e.name, "clr_ready", {3'b0, clr_ready}, {3'b0, e.rdy});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // 1: reset with a level held high
    cyc(1, 4'b0101, 4'hF, 0, 4'h0);
    cyc(1, 4'b0101, 4'hF, 0, 4'h0);
    expect_out("reset", C_ALL, 0, 2'd0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'b0101, 4'hF, 0, 4'h0);
      expect_out("post_reset", C_ALL, 0, 2'd0, 4'h0, 4'h0, 1);
    end
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("fall_no_evt", C_PND | C_CNT | C_IRQ, 0, 2'd0, 4'h0, 4'h0, 1);

    // 2: single pulse on src[2]
    cyc(0, 4'b0100, 4'hF, 0, 4'h0);
    expect_out("t2_pend", C_IRQ | C_PND | C_CNT, 0, 2'd0, 4'b0100, 4'd1, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t2_irq", C_IRQ | C_ID | C_PND | C_CNT, 1, 2'd2, 4'b0100, 4'd1, 1);
    cyc(0, 4'b0000, 4'hF, 1, 4'b0100);
    expect_out("t2_clr", C_IRQ | C_PND, 0, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t2_hold1", C_IRQ, 0, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t2_hold2", C_IRQ, 0, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);

    // 3: two pending, clear the signalled one, hold-off, then next id
    cyc(0, 4'b1010, 4'hF, 0, 4'h0);
    expect_out("t3_pend", C_IRQ | C_PND | C_CNT, 0, 2'd0, 4'b1010, 4'd2, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t3_irq1", C_IRQ | C_ID | C_PND, 1, 2'd1, 4'b1010, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 1, 4'b0010);
    expect_out("t3_clr", C_IRQ | C_PND, 0, 2'd0, 4'b1000, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t3_hold1", C_IRQ, 0, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t3_hold2", C_IRQ, 0, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t3_irq3", C_IRQ | C_ID | C_PND, 1, 2'd3, 4'b1000, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 1, 4'b1000);
    expect_out("t3_clr3", C_IRQ | C_PND, 0, 2'd0, 4'h0, 4'h0, 1);
    repeat (3) cyc(0, 4'b0000, 4'hF, 0, 4'h0);

    // 4: rise and clear on the same bit in the same cycle
    cyc(0, 4'b0001, 4'hF, 0, 4'h0);
    expect_out("t4_pend", C_PND | C_CNT, 0, 2'd0, 4'b0001, 4'd3, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t4_irq0", C_IRQ | C_ID, 1, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0001, 4'hF, 1, 4'b0001);
    expect_out("t4_setwins", C_IRQ | C_PND | C_CNT, 0, 2'd0, 4'b0001, 4'd4, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t4_hold2", C_IRQ | C_PND, 0, 2'd0, 4'b0001, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t4_reirq", C_IRQ | C_ID, 1, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'hF, 1, 4'b0001);
    expect_out("t4_clr", C_IRQ | C_PND, 0, 2'd0, 4'h0, 4'h0, 1);
    repeat (3) cyc(0, 4'b0000, 4'hF, 0, 4'h0);

    // 5: masked pending, unmask later, clear of a non-signalled bit
    cyc(0, 4'b0010, 4'h0, 0, 4'h0);
    expect_out("t5_pend", C_IRQ | C_PND | C_CNT, 0, 2'd0, 4'b0010, 4'd5, 1);
    cyc(0, 4'b1000, 4'h0, 0, 4'h0);
    expect_out("t5_masked", C_IRQ | C_PND | C_CNT, 0, 2'd0, 4'b1010, 4'd6, 1);
    cyc(0, 4'b0000, 4'h0, 0, 4'h0);
    expect_out("t5_masked2", C_IRQ, 0, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'b1010, 0, 4'h0);
    expect_out("t5_unmask1", C_IRQ, 0, 2'd0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'b1010, 0, 4'h0);
    expect_out("t5_unmask2", C_IRQ | C_ID, 1, 2'd1, 4'h0, 4'h0, 1);
    cyc(0, 4'b0000, 4'b1010, 1, 4'b1000);
    expect_out("t5_otherclr", C_IRQ | C_ID | C_PND, 1, 2'd1, 4'b0010, 4'h0, 1);
    cyc(0, 4'b0000, 4'b1010, 1, 4'b0010);
    expect_out("t5_clr", C_IRQ | C_PND, 0, 2'd0, 4'h0, 4'h0, 1);
    repeat (3) cyc(0, 4'b0000, 4'hF, 0, 4'h0);

    // 6: counter saturation, then reset while active
    for (int j = 0; j < 20; j++) begin
      cyc(0, (j % 2 == 0) ? 4'b0001 : 4'b0010, 4'hF, 0, 4'h0);
      if (j == 7)  expect_out("t6_cnt14", C_CNT, 0, 2'd0, 4'h0, 4'd14, 1);
      if (j == 8)  expect_out("t6_cnt15", C_CNT, 0, 2'd0, 4'h0, 4'd15, 1);
      if (j == 19) expect_out("t6_sat",   C_IRQ | C_ID | C_PND | C_CNT, 1, 2'd0, 4'b0011, 4'd15, 1);
    end
    cyc(1, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t6_rst_active", C_ALL, 0, 2'd0, 4'h0, 4'h0, 0);
    cyc(0, 4'b0000, 4'hF, 0, 4'h0);
    expect_out("t6_after_rst", C_ALL, 0, 2'd0, 4'h0, 4'h0, 1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
